// File: rtl/fs_accel_cfg_master_if.sv
// Accelerator control-port bus between the config master and the control slave.
// Writes are single-cycle strobes with no ready/backpressure; the read side is a
// continuously driven status word at a fixed address.
interface fs_accel_cfg_master_if;
  logic        al_accel_mem_valid;
  logic [31:0] al_accel_ctrl_waddr;
  logic [31:0] al_accel_ctrl_wdata;
  logic [31:0] al_accel_ctrl_raddr;
  logic [31:0] al_accel_ctrl_rdata;

  modport master (
    output al_accel_mem_valid,
    output al_accel_ctrl_waddr,
    output al_accel_ctrl_wdata,
    output al_accel_ctrl_raddr,
    input  al_accel_ctrl_rdata
  );

  modport slave (
    input  al_accel_mem_valid,
    input  al_accel_ctrl_waddr,
    input  al_accel_ctrl_wdata,
    input  al_accel_ctrl_raddr,
    output al_accel_ctrl_rdata
  );
endinterface

// File: rtl/fs_accel_cfg_master.sv
// fs_accel_cfg_master: runs one accelerator job end to end without the CPU.
// Sequence: slave -> CFG, copy NUM_CFG words from the config ROM into the slave's
// config registers, slave -> RUN, poll status until FIN, slave -> RST, pulse done.
// Optional build macro FS_ACCEL_CFG_WDOG_EN adds a WAIT_FIN watchdog that gives up
// after TIMEOUT_CYC cycles and flags err_timeout; without it err_timeout is tied low.
module fs_accel_cfg_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_1000,
  parameter logic [31:0] CTRL_ADDR   = 32'h0200_1050,
  parameter int          NUM_CFG     = 19,
  parameter int          ROM_AW      = 5,
  parameter int          TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [ROM_AW-1:0]     cfg_rom_addr,
  input  logic [31:0]           cfg_rom_rdata,
  fs_accel_cfg_master_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_abort,
  output logic                  err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER_CFG,
    S_FETCH,
    S_WR_REG,
    S_ENTER_RUN,
    S_WAIT_FIN,
    S_EXIT,
    S_DONE
  } state_t;

  localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(NUM_CFG - 1);
  localparam logic [ROM_AW-1:0] IDX_ONE  = ROM_AW'(1);

  state_t            state;
  state_t            state_next;
  logic [ROM_AW-1:0] idx;
  logic [ROM_AW-1:0] idx_next;
  logic              clr_err;
  logic              set_abort;
  logic              set_timeout;
  logic              wdog_expired;
  logic              abortable;
  logic              fin_seen;
  logic              wr_valid;
  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;
  logic [31:0]       reg_addr;
  logic [29:0]       unused_rdata;

  // Only the mode field of the status word matters to this master.
  assign fin_seen     = (bus.al_accel_ctrl_rdata[1:0] == 2'd3);
  assign unused_rdata = bus.al_accel_ctrl_rdata[31:2];

  // Config register idx sits at BASE_ADDR + 4*idx; idx is zero-extended to 32 bits.
  assign reg_addr = BASE_ADDR + {{(30 - ROM_AW){1'b0}}, idx, 2'b00};

  // abort is honoured only while a job is actively configuring or running.
  assign abortable = (state == S_ENTER_CFG) || (state == S_FETCH) ||
                     (state == S_WR_REG)    || (state == S_ENTER_RUN) ||
                     (state == S_WAIT_FIN);

  // State and ROM index registers; reset drops any job in progress straight to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state, index update and the write strobe decoded from the current state.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    clr_err     = 1'b0;
    set_abort   = 1'b0;
    set_timeout = 1'b0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_ENTER_CFG;
          idx_next   = '0;
          clr_err    = 1'b1;
        end
      end
      S_ENTER_CFG: begin
        wr_valid   = 1'b1;
        wr_addr    = CTRL_ADDR;
        wr_data    = 32'd1;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        state_next = S_WR_REG;
      end
      S_WR_REG: begin
        wr_valid = 1'b1;
        wr_addr  = reg_addr;
        wr_data  = cfg_rom_rdata;
        if (idx == LAST_IDX) begin
          state_next = S_ENTER_RUN;
        end else begin
          idx_next   = idx + IDX_ONE;
          state_next = S_FETCH;
        end
      end
      S_ENTER_RUN: begin
        wr_valid   = 1'b1;
        wr_addr    = CTRL_ADDR;
        wr_data    = 32'd2;
        state_next = S_WAIT_FIN;
      end
      S_WAIT_FIN: begin
        if (fin_seen) begin
          state_next = S_EXIT;
        end else if (wdog_expired) begin
          state_next  = S_EXIT;
          set_timeout = 1'b1;
        end
      end
      S_EXIT: begin
        wr_valid   = 1'b1;
        wr_addr    = CTRL_ADDR;
        wr_data    = 32'd0;
        state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // abort overrides FIN and watchdog expiry; the write decoded above still goes out.
    if (abort && abortable) begin
      state_next  = S_EXIT;
      idx_next    = idx;
      set_abort   = 1'b1;
      set_timeout = 1'b0;
    end
  end

  // Sticky abort flag, cleared only when a new job is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_abort <= 1'b0;
    end else if (clr_err) begin
      err_abort <= 1'b0;
    end else if (set_abort) begin
      err_abort <= 1'b1;
    end
  end

`ifdef FS_ACCEL_CFG_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wdog_cnt;

  // Counts cycles spent in WAIT_FIN; zero on the first cycle of every visit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt <= '0;
    end else if (state != S_WAIT_FIN) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + 16'd1;
    end
  end

  // Expiry on the TIMEOUT_CYC-th WAIT_FIN cycle, so EXIT follows TIMEOUT_CYC cycles after entry.
  assign wdog_expired = (state == S_WAIT_FIN) && (wdog_cnt == WDOG_LAST);

  // Sticky timeout flag, cleared only when a new job is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_timeout <= 1'b0;
    end else if (clr_err) begin
      err_timeout <= 1'b0;
    end else if (set_timeout) begin
      err_timeout <= 1'b1;
    end
  end
`else
  logic [16:0] unused_wdog;

  assign wdog_expired = 1'b0;
  assign err_timeout  = 1'b0;
  assign unused_wdog  = {set_timeout, 16'(TIMEOUT_CYC)};
`endif

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign cfg_rom_addr = idx;

  assign bus.al_accel_mem_valid  = wr_valid;
  assign bus.al_accel_ctrl_waddr = wr_addr;
  assign bus.al_accel_ctrl_wdata = wr_data;
  assign bus.al_accel_ctrl_raddr = CTRL_ADDR;

endmodule

// File: tb/tb_fs_accel_cfg_master.sv
// Directed bench for fs_accel_cfg_master: ROM model holding A000_0000+i, a
// behavioural control slave that reports FIN a programmable delay after RUN,
// and a write log stamped with the cycle number each write was seen in.
module tb_fs_accel_cfg_master;

  localparam logic [31:0] BASE = 32'h0200_1000;
  localparam logic [31:0] CTRL = 32'h0200_1050;
  localparam int          NUM  = 19;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  rom_addr;
  logic [31:0] rom_q = 32'd0;
  logic        busy;
  logic        done;
  logic        err_abort;
  logic        err_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [1:0] mode      = 2'd0;
  bit         fin_en    = 1'b0;
  int         fin_delay = 100;
  int         fin_at    = -1;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  fs_accel_cfg_master_if bus ();

  fs_accel_cfg_master #(
    .BASE_ADDR  (BASE),
    .CTRL_ADDR  (CTRL),
    .NUM_CFG    (NUM),
    .ROM_AW     (5),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .cfg_rom_addr (rom_addr),
    .cfg_rom_rdata(rom_q),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err_abort    (err_abort),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rom_q <= 32'hA000_0000 + {27'd0, rom_addr};

  assign bus.al_accel_ctrl_rdata = {30'd0, mode};

  // Slave model and write log, sampled just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      mode = 2'd0;
    end else if (bus.al_accel_mem_valid === 1'b1) begin
      wr_addr_q.push_back(bus.al_accel_ctrl_waddr);
      wr_data_q.push_back(bus.al_accel_ctrl_wdata);
      wr_cyc_q.push_back(cyc);
      if (bus.al_accel_ctrl_waddr == CTRL) begin
        mode = bus.al_accel_ctrl_wdata[1:0];
        if (bus.al_accel_ctrl_wdata[1:0] == 2'd2) fin_at = cyc + fin_delay;
      end
    end else if (fin_en && mode == 2'd2 && cyc == fin_at) begin
      mode = 2'd3;
    end
  end

  task automatic wait_done(input int max, output int dcyc, output bit ok);
    ok = 1'b0;
    dcyc = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcyc = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_write(input logic [31:0] a, input logic [31:0] d, input int max,
                            output int wc, output bit ok);
    ok = 1'b0;
    wc = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.al_accel_mem_valid === 1'b1 && bus.al_accel_ctrl_waddr === a &&
          bus.al_accel_ctrl_wdata === d) begin
        wc = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (err_abort !== 1'b0) $display("[TB] FAIL reset_err_abort: got %b want 0", err_abort); else n_pass++;
    n_checks++; if (err_timeout !== 1'b0) $display("[TB] FAIL reset_err_timeout: got %b want 0", err_timeout); else n_pass++;
    n_checks++; if (bus.al_accel_mem_valid !== 1'b0) $display("[TB] FAIL reset_mem_valid: got %b want 0", bus.al_accel_mem_valid); else n_pass++;
    n_checks++; if (bus.al_accel_ctrl_waddr !== 32'd0) $display("[TB] FAIL reset_waddr: got %h want 0", bus.al_accel_ctrl_waddr); else n_pass++;
    n_checks++; if (bus.al_accel_ctrl_wdata !== 32'd0) $display("[TB] FAIL reset_wdata: got %h want 0", bus.al_accel_ctrl_wdata); else n_pass++;
    n_checks++; if (bus.al_accel_ctrl_raddr !== CTRL) $display("[TB] FAIL reset_raddr: got %h want %h", bus.al_accel_ctrl_raddr, CTRL); else n_pass++;
    n_checks++; if (rom_addr !== 5'd0) $display("[TB] FAIL reset_rom_addr: got %h want 0", rom_addr); else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_config_job;
    int s, base, n, dcyc;
    bit ok;
    logic [31:0] ea, ed;
    int ec;
    @(negedge clk);
    fin_en = 1'b1;
    fin_delay = 100;
    base = wr_addr_q.size();
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("[TB] FAIL job_busy_rise: got %b want 1", busy); else n_pass++;
    wait_done(400, dcyc, ok);
    n_checks++; if (!ok) $display("[TB] FAIL job_done_timeout: got no done want done within 400"); else n_pass++;
    n = wr_addr_q.size() - base;
    n_checks++; if (n != NUM + 3) $display("[TB] FAIL job_write_count: got %0d want %0d", n, NUM + 3); else n_pass++;
    for (int k = 0; k < NUM + 3; k++) begin
      if (k == 0) begin
        ea = CTRL; ed = 32'd1; ec = s + 1;
      end else if (k <= NUM) begin
        ea = BASE + 32'(4 * (k - 1)); ed = 32'hA000_0000 + 32'(k - 1); ec = s + 3 + 2 * (k - 1);
      end else if (k == NUM + 1) begin
        ea = CTRL; ed = 32'd2; ec = s + 40;
      end else begin
        ea = CTRL; ed = 32'd0; ec = s + 141;
      end
      if (k < n) begin
        n_checks++;
        if (wr_addr_q[base + k] !== ea || wr_data_q[base + k] !== ed || wr_cyc_q[base + k] != ec)
          $display("[TB] FAIL job_write[%0d]: got %h=%h @%0d want %h=%h @%0d", k,
                   wr_addr_q[base + k], wr_data_q[base + k], wr_cyc_q[base + k], ea, ed, ec);
        else n_pass++;
      end
    end
    n_checks++; if (dcyc != s + 142) $display("[TB] FAIL job_done_cycle: got %0d want %0d", dcyc, s + 142); else n_pass++;
    n_checks++; if (err_abort !== 1'b0 || err_timeout !== 1'b0)
      $display("[TB] FAIL job_flags: got abort=%b timeout=%b want 0 0", err_abort, err_timeout); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL job_after_done: got busy=%b done=%b want 0 0", busy, done); else n_pass++;
  endtask

  task automatic test_abort;
    int s, base, a, dcyc, n;
    bit ok;
    @(negedge clk);
    fin_en = 1'b1;
    fin_delay = 100;
    base = wr_addr_q.size();
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_write(BASE + 32'd20, 32'hA000_0005, 100, a, ok);
    n_checks++; if (!ok || a != s + 13) $display("[TB] FAIL abort_reg5_seen: got ok=%b @%0d want 1 @%0d", ok, a, s + 13); else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(20, dcyc, ok);
    n_checks++; if (!ok || dcyc != a + 2) $display("[TB] FAIL abort_done_cycle: got ok=%b @%0d want 1 @%0d", ok, dcyc, a + 2); else n_pass++;
    n = wr_addr_q.size() - base;
    n_checks++; if (n != 8) $display("[TB] FAIL abort_write_count: got %0d want 8", n); else n_pass++;
    if (n >= 8) begin
      n_checks++;
      if (wr_addr_q[base + 6] !== BASE + 32'd20 || wr_addr_q[base + 7] !== CTRL ||
          wr_data_q[base + 7] !== 32'd0 || wr_cyc_q[base + 7] != a + 1)
        $display("[TB] FAIL abort_exit_write: got %h then %h=%h @%0d want %h then %h=0 @%0d",
                 wr_addr_q[base + 6], wr_addr_q[base + 7], wr_data_q[base + 7], wr_cyc_q[base + 7],
                 BASE + 32'd20, CTRL, a + 1);
      else n_pass++;
    end
    n_checks++; if (err_abort !== 1'b1 || err_timeout !== 1'b0)
      $display("[TB] FAIL abort_flags: got abort=%b timeout=%b want 1 0", err_abort, err_timeout); else n_pass++;
    repeat (30) @(negedge clk);
    n_checks++; if (wr_addr_q.size() != base + 8) $display("[TB] FAIL abort_no_more_writes: got %0d want %0d", wr_addr_q.size() - base, 8); else n_pass++;
  endtask

  task automatic test_abort_with_fin;
    int dcyc;
    bit ok;
    @(negedge clk);
    fin_en = 1'b1;
    fin_delay = 4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (err_abort !== 1'b0) $display("[TB] FAIL start_clears_abort: got %b want 0", err_abort); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.al_accel_ctrl_rdata[1:0] == 2'd3) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok) $display("[TB] FAIL abort_fin_seen: got no FIN want FIN within 200"); else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (bus.al_accel_mem_valid !== 1'b1 || bus.al_accel_ctrl_waddr !== CTRL || bus.al_accel_ctrl_wdata !== 32'd0)
      $display("[TB] FAIL abort_fin_exit: got v=%b %h=%h want 1 %h=0", bus.al_accel_mem_valid,
               bus.al_accel_ctrl_waddr, bus.al_accel_ctrl_wdata, CTRL); else n_pass++;
    wait_done(5, dcyc, ok);
    n_checks++; if (!ok || err_abort !== 1'b1 || err_timeout !== 1'b0)
      $display("[TB] FAIL abort_fin_flags: got done=%b abort=%b timeout=%b want 1 1 0", ok, err_abort, err_timeout); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int base, d1, d2, n_cfg;
    bit ok;
    @(negedge clk);
    fin_en = 1'b1;
    fin_delay = 5;
    base = wr_addr_q.size();
    start = 1'b1;
    wait_done(200, d1, ok);
    n_checks++; if (!ok) $display("[TB] FAIL b2b_done1_timeout: got no done want done within 200"); else n_pass++;
    n_cfg = 0;
    for (int k = base; k < wr_addr_q.size(); k++)
      if (wr_addr_q[k] == CTRL && wr_data_q[k] == 32'd1) n_cfg++;
    n_checks++; if (n_cfg != 1 || wr_addr_q.size() - base != NUM + 3)
      $display("[TB] FAIL b2b_single_job: got %0d starts %0d writes want 1 %0d", n_cfg, wr_addr_q.size() - base, NUM + 3); else n_pass++;
    n_checks++; if (err_abort !== 1'b0) $display("[TB] FAIL b2b_flag_cleared: got %b want 0", err_abort); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL b2b_idle_gap: got busy=%b want 0", busy); else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || bus.al_accel_ctrl_waddr !== CTRL || bus.al_accel_ctrl_wdata !== 32'd1)
      $display("[TB] FAIL b2b_start_beats_abort: got busy=%b %h=%h want 1 %h=1", busy,
               bus.al_accel_ctrl_waddr, bus.al_accel_ctrl_wdata, CTRL); else n_pass++;
    abort = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (bus.al_accel_mem_valid !== 1'b1 || bus.al_accel_ctrl_waddr !== CTRL || bus.al_accel_ctrl_wdata !== 32'd0)
      $display("[TB] FAIL b2b_fetch_abort_exit: got v=%b %h=%h want 1 %h=0", bus.al_accel_mem_valid,
               bus.al_accel_ctrl_waddr, bus.al_accel_ctrl_wdata, CTRL); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || err_abort !== 1'b1)
      $display("[TB] FAIL b2b_abort_done: got done=%b abort=%b want 1 1", done, err_abort); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || err_abort !== 1'b1)
      $display("[TB] FAIL b2b_idle_sticky: got busy=%b abort=%b want 0 1", busy, err_abort); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || err_abort !== 1'b0 || bus.al_accel_ctrl_wdata !== 32'd1)
      $display("[TB] FAIL b2b_restart_clears: got busy=%b abort=%b wdata=%h want 1 0 1", busy, err_abort, bus.al_accel_ctrl_wdata); else n_pass++;
    start = 1'b0;
    wait_done(200, d2, ok);
    n_checks++; if (!ok || err_abort !== 1'b0)
      $display("[TB] FAIL b2b_done2: got done=%b abort=%b want 1 0", ok, err_abort); else n_pass++;
  endtask

  task automatic test_reset_mid_job;
    int r, base;
    bit ok;
    @(negedge clk);
    fin_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_write(CTRL, 32'd2, 100, r, ok);
    n_checks++; if (!ok) $display("[TB] FAIL rst_run_seen: got no RUN write want RUN within 100"); else n_pass++;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || bus.al_accel_mem_valid !== 1'b0 || bus.al_accel_ctrl_waddr !== 32'd0)
      $display("[TB] FAIL rst_async_outputs: got busy=%b done=%b v=%b waddr=%h want 0 0 0 0",
               busy, done, bus.al_accel_mem_valid, bus.al_accel_ctrl_waddr); else n_pass++;
    n_checks++; if (err_abort !== 1'b0 || err_timeout !== 1'b0 || rom_addr !== 5'd0 || bus.al_accel_ctrl_raddr !== CTRL)
      $display("[TB] FAIL rst_async_flags: got abort=%b timeout=%b rom=%h raddr=%h want 0 0 0 %h",
               err_abort, err_timeout, rom_addr, bus.al_accel_ctrl_raddr, CTRL); else n_pass++;
    base = wr_addr_q.size();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (wr_addr_q.size() != base || busy !== 1'b0)
      $display("[TB] FAIL rst_quiet_after: got %0d writes busy=%b want 0 0", wr_addr_q.size() - base, busy); else n_pass++;
  endtask

  task automatic test_watchdog;
    int r, x, dcyc, base;
    bit ok;
    @(negedge clk);
    fin_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_write(CTRL, 32'd2, 100, r, ok);
    n_checks++; if (!ok) $display("[TB] FAIL wdog_run_seen: got no RUN write want RUN within 100"); else n_pass++;
`ifdef FS_ACCEL_CFG_WDOG_EN
    wait_write(CTRL, 32'd0, 200, x, ok);
    n_checks++; if (!ok || x != r + 51) $display("[TB] FAIL wdog_exit_cycle: got ok=%b @%0d want 1 @%0d", ok, x, r + 51); else n_pass++;
    wait_done(5, dcyc, ok);
    n_checks++; if (!ok || err_timeout !== 1'b1 || err_abort !== 1'b0)
      $display("[TB] FAIL wdog_flags: got done=%b timeout=%b abort=%b want 1 1 0", ok, err_timeout, err_abort); else n_pass++;
`else
    base = wr_addr_q.size();
    x = r;
    repeat (10000) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || wr_addr_q.size() != base || err_timeout !== 1'b0)
      $display("[TB] FAIL nowdog_still_waiting: got busy=%b writes=%0d timeout=%b want 1 0 0",
               busy, wr_addr_q.size() - base, err_timeout); else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(5, dcyc, ok);
    n_checks++; if (!ok || err_abort !== 1'b1 || err_timeout !== 1'b0)
      $display("[TB] FAIL nowdog_abort_exit: got done=%b abort=%b timeout=%b want 1 1 0", ok, err_abort, err_timeout); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_config_job();
    test_abort();
    test_abort_with_fin();
    test_back_to_back();
    test_reset_mid_job();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish want finish before 500000ns");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
